// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALUop classes and the
// control-bundle type carried through the ID/EX register.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CB and B formats match only on an opcode prefix.
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0]  XZR     = 5'd31;

  typedef enum logic [1:0] {
    ALU_LDST = 2'b00,
    ALU_CB   = 2'b01,
    ALU_R    = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   ubranch;
    logic   branch;
    logic   memread;
    logic   memtoreg;
    logic   memwrite;
    logic   alusrc;
    logic   regwrite;
    logic   illegal;
    aluop_e aluop;
  } ctrl_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/legv8_rf_bypass.sv
// 2-read / 1-write register file with XZR hard-wired to zero and write-through
// bypass so a same-cycle write-back is visible to decode.
module legv8_rf_bypass
  import legv8_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != XZR)) begin
      regs[wa] <= wd;
    end
  end

  // wa == ra implies wa != XZR here, since XZR reads are caught first.
  assign rd1 = (ra1 == XZR)            ? '0 :
               (we && (wa == ra1))     ? wd : regs[ra1];
  assign rd2 = (ra2 == XZR)            ? '0 :
               (we && (wa == ra2))     ? wd : regs[ra2];

endmodule

// File: rtl/legv8_id_stage.sv
// LEGv8 instruction-decode stage: field/control decode, register read with
// write-back bypass, load-use stall and flush handling into the ID/EX register.
module legv8_id_stage
  import legv8_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  input  logic            out_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rn,
  output logic [4:0]      out_rm,
  output logic [4:0]      out_rd,
  output logic            out_ubranch,
  output logic            out_branch,
  output logic            out_memread,
  output logic            out_memtoreg,
  output logic            out_memwrite,
  output logic            out_alusrc,
  output logic            out_regwrite,
  output logic [1:0]      out_aluop,
  output logic            out_illegal
);

  function automatic logic [XLEN-1:0] sext(input logic [25:0] field, input int bits);
    logic signed [XLEN-1:0] t;
    t = $signed({{(XLEN-26){1'b0}}, field}) <<< (XLEN - bits);
    return t >>> (XLEN - bits);
  endfunction

  logic [10:0]     op_p0;
  logic [4:0]      rn_p0;
  logic [4:0]      rm_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] imm_p0;
  logic [XLEN-1:0] rd1_p0;
  logic [XLEN-1:0] rd2_p0;
  ctrl_t           ctrl_p0;
  logic            uses_rm_p0;
  logic            hazard;

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rd1_p1;
  logic [XLEN-1:0] rd2_p1;
  logic [XLEN-1:0] imm_p1;
  logic [4:0]      rn_p1;
  logic [4:0]      rm_p1;
  logic [4:0]      rd_p1;
  ctrl_t           ctrl_p1;

  // ---- p0: decode and register read ----
  assign op_p0 = in_inst[31:21];
  assign rn_p0 = in_inst[9:5];
  assign rm_p0 = in_inst[28] ? in_inst[4:0] : in_inst[20:16];
  assign rd_p0 = in_inst[4:0];

  always_comb begin
    ctrl_p0    = '0;
    uses_rm_p0 = 1'b0;
    imm_p0     = '0;
    if (is_rtype(op_p0)) begin
      ctrl_p0.regwrite = 1'b1;
      ctrl_p0.aluop    = ALU_R;
      uses_rm_p0       = 1'b1;
    end else if (op_p0 == OP_LDUR) begin
      ctrl_p0.alusrc   = 1'b1;
      ctrl_p0.memread  = 1'b1;
      ctrl_p0.memtoreg = 1'b1;
      ctrl_p0.regwrite = 1'b1;
      ctrl_p0.aluop    = ALU_LDST;
      imm_p0           = sext({17'b0, in_inst[20:12]}, 9);
    end else if (op_p0 == OP_STUR) begin
      ctrl_p0.alusrc   = 1'b1;
      ctrl_p0.memwrite = 1'b1;
      ctrl_p0.aluop    = ALU_LDST;
      uses_rm_p0       = 1'b1;
      imm_p0           = sext({17'b0, in_inst[20:12]}, 9);
    end else if (op_p0[10:3] == OP_CBZ) begin
      ctrl_p0.branch   = 1'b1;
      ctrl_p0.aluop    = ALU_CB;
      uses_rm_p0       = 1'b1;
      imm_p0           = sext({7'b0, in_inst[23:5]}, 19);
    end else if (op_p0[10:5] == OP_B) begin
      ctrl_p0.ubranch  = 1'b1;
      imm_p0           = sext(in_inst[25:0], 26);
    end else begin
      ctrl_p0.illegal  = 1'b1;
    end
  end

  legv8_rf_bypass #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rn_p0),
    .ra2 (rm_p0),
    .rd1 (rd1_p0),
    .rd2 (rd2_p0),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  // A load sitting in ID/EX cannot forward to the instruction now in decode.
  assign hazard = (HAZARD_EN != 0) && vld_p1 && ctrl_p1.memread && (rd_p1 != XZR) &&
                  ((rd_p1 == rn_p0) || (uses_rm_p0 && (rd_p1 == rm_p0)));

  assign in_ready = !rst && out_ready && !hazard;

  // ---- p1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      pc_p1   <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      imm_p1  <= '0;
      rn_p1   <= '0;
      rm_p1   <= '0;
      rd_p1   <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (out_ready) begin
      if (in_valid && in_ready) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
        pc_p1   <= in_pc;
        rd1_p1  <= rd1_p0;
        rd2_p1  <= rd2_p0;
        imm_p1  <= imm_p0;
        rn_p1   <= rn_p0;
        rm_p1   <= rm_p0;
        rd_p1   <= rd_p0;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_pc       = pc_p1;
  assign out_rd1      = rd1_p1;
  assign out_rd2      = rd2_p1;
  assign out_imm      = imm_p1;
  assign out_rn       = rn_p1;
  assign out_rm       = rm_p1;
  assign out_rd       = rd_p1;
  assign out_ubranch  = ctrl_p1.ubranch;
  assign out_branch   = ctrl_p1.branch;
  assign out_memread  = ctrl_p1.memread;
  assign out_memtoreg = ctrl_p1.memtoreg;
  assign out_memwrite = ctrl_p1.memwrite;
  assign out_alusrc   = ctrl_p1.alusrc;
  assign out_regwrite = ctrl_p1.regwrite;
  assign out_aluop    = ctrl_p1.aluop;
  assign out_illegal  = ctrl_p1.illegal;

endmodule

// File: tb/tb_legv8_id_stage.sv
// Scoreboard bench for legv8_id_stage: directed instructions push expected
// ID/EX contents; a negedge monitor pops and compares on each transfer.
module tb_legv8_id_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
  } exp_t;

  // {ubranch, branch, memread, memtoreg, memwrite, alusrc, regwrite, illegal, aluop}
  localparam logic [9:0] C_R   = 10'b00000010_10;
  localparam logic [9:0] C_LD  = 10'b00110110_00;
  localparam logic [9:0] C_ST  = 10'b00001100_00;
  localparam logic [9:0] C_CB  = 10'b01000000_01;
  localparam logic [9:0] C_B   = 10'b10000000_00;
  localparam logic [9:0] C_ILL = 10'b00000001_00;

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;
  localparam logic [10:0] LDR = 11'b11111000010;
  localparam logic [10:0] STR = 11'b11111000000;

  logic        clk, rst, in_valid, in_ready, out_ready, flush, wb_we;
  logic [31:0] in_inst;
  logic [63:0] in_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        out_valid, out_ubranch, out_branch, out_memread, out_memtoreg;
  logic        out_memwrite, out_alusrc, out_regwrite, out_illegal;
  logic [63:0] out_pc, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rn, out_rm, out_rd;
  logic [1:0]  out_aluop;

  logic        nh_in_ready, nh_out_valid, nh_ubranch, nh_branch, nh_memread, nh_memtoreg;
  logic        nh_memwrite, nh_alusrc, nh_regwrite, nh_illegal;
  logic [63:0] nh_pc, nh_rd1, nh_rd2, nh_imm;
  logic [4:0]  nh_rn, nh_rm, nh_rd;
  logic [1:0]  nh_aluop;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  legv8_id_stage #(.XLEN(64), .HAZARD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .out_ready(out_ready), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2),
    .out_imm(out_imm), .out_rn(out_rn), .out_rm(out_rm), .out_rd(out_rd),
    .out_ubranch(out_ubranch), .out_branch(out_branch), .out_memread(out_memread),
    .out_memtoreg(out_memtoreg), .out_memwrite(out_memwrite), .out_alusrc(out_alusrc),
    .out_regwrite(out_regwrite), .out_aluop(out_aluop), .out_illegal(out_illegal)
  );

  legv8_id_stage #(.XLEN(64), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(nh_in_ready), .out_ready(out_ready), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(nh_out_valid), .out_pc(nh_pc), .out_rd1(nh_rd1), .out_rd2(nh_rd2),
    .out_imm(nh_imm), .out_rn(nh_rn), .out_rm(nh_rm), .out_rd(nh_rd),
    .out_ubranch(nh_ubranch), .out_branch(nh_branch), .out_memread(nh_memread),
    .out_memtoreg(nh_memtoreg), .out_memwrite(nh_memwrite), .out_alusrc(nh_alusrc),
    .out_regwrite(nh_regwrite), .out_aluop(nh_aluop), .out_illegal(nh_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, rd1, rd2, imm,
                              input logic [4:0] rn, rm, rd, input logic [9:0] ctrl);
    exp_t e;
    e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.rn = rn; e.rm = rm; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic logic [31:0] r_t(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'b0, rn, rd};
  endfunction

  function automatic logic [31:0] d_t(input logic [10:0] op, input logic [8:0] imm,
                                      input logic [4:0] rn, rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_we = 1'b0;
  endtask

  // Presents an instruction until accepted, counting stall cycles.
  task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input exp_t e,
                       input bit push, input int exp_stalls);
    int stalls = 0;
    bit done = 1'b0;
    in_inst = inst; in_pc = pc; in_valid = 1'b1;
    for (int c = 0; c < 6 && !done; c++) begin
      #1;
      if (in_ready) begin
        if (push) sb.push_back(e);
        done = 1'b1;
        step();
      end else begin
        stalls++;
        chk("nohaz_ready", {63'b0, nh_in_ready}, 64'd1);
        step();
        chk("bubble_valid", {63'b0, out_valid}, 64'd0);
        chk("nohaz_accept", {63'b0, nh_out_valid}, 64'd1);
      end
    end
    in_valid = 1'b0;
    chk("accepted", {63'b0, done}, 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready && !flush && !rst) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pc",   out_pc,  e.pc);
        chk("rd1",  out_rd1, e.rd1);
        chk("rd2",  out_rd2, e.rd2);
        chk("imm",  out_imm, e.imm);
        chk("rn",   64'(out_rn), 64'(e.rn));
        chk("rm",   64'(out_rm), 64'(e.rm));
        chk("rd",   64'(out_rd), 64'(e.rd));
        chk("ctrl", 64'({out_ubranch, out_branch, out_memread, out_memtoreg, out_memwrite,
                         out_alusrc, out_regwrite, out_illegal, out_aluop}), 64'(e.ctrl));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

    step();
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("post_rst_pc", out_pc, 64'd0);
    chk("post_rst_imm", out_imm, 64'd0);
    chk("post_rst_regwrite", {63'b0, out_regwrite}, 64'd0);
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    step();

    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    wb(5'd4, 64'h40);
    wb(5'd6, 64'h66);

    issue(32'h8B020023, 64'h100, mk(64'h100, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3, C_R), 1, 0);
    issue(d_t(LDR, 9'd8, 5'd1, 5'd4), 64'h104,
          mk(64'h104, 64'd5, 64'h40, 64'd8, 5'd1, 5'd4, 5'd4, C_LD), 1, 0);
    issue(r_t(ADD, 5'd2, 5'd4, 5'd5), 64'h108,
          mk(64'h108, 64'h40, 64'd7, 64'd0, 5'd4, 5'd2, 5'd5, C_R), 1, 1);
    issue(d_t(STR, 9'h1F8, 5'd1, 5'd6), 64'h10C,
          mk(64'h10C, 64'd5, 64'h66, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd6, 5'd6, C_ST), 1, 0);
    issue({8'hB4, 19'h7FFFF, 5'd3}, 64'h110,
          mk(64'h110, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd3, 5'd3, C_CB), 1, 0);
    issue(32'h1400_0001, 64'h114,
          mk(64'h114, 64'd0, 64'd5, 64'd1, 5'd0, 5'd1, 5'd1, C_B), 1, 0);

    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 64'hABCD;
    issue(r_t(ADD, 5'd2, 5'd7, 5'd8), 64'h118,
          mk(64'h118, 64'hABCD, 64'd7, 64'd0, 5'd7, 5'd2, 5'd8, C_R), 1, 0);
    wb_we = 1'b0;
    wb(5'd31, 64'h99);
    issue(r_t(ADD, 5'd31, 5'd31, 5'd9), 64'h11C,
          mk(64'h11C, 64'd0, 64'd0, 64'd0, 5'd31, 5'd31, 5'd9, C_R), 1, 0);
    wb_we = 1'b1; wb_rd = 5'd31; wb_data = 64'h55;
    issue(r_t(ADD, 5'd7, 5'd31, 5'd10), 64'h120,
          mk(64'h120, 64'd0, 64'hABCD, 64'd0, 5'd31, 5'd7, 5'd10, C_R), 1, 0);
    wb_we = 1'b0;

    issue(r_t(SUB, 5'd1, 5'd7, 5'd11), 64'h124,
          mk(64'h124, 64'hABCD, 64'd5, 64'd0, 5'd7, 5'd1, 5'd11, C_R), 1, 0);
    issue(r_t(AND, 5'd2, 5'd1, 5'd12), 64'h128,
          mk(64'h128, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd12, C_R), 1, 0);
    issue(r_t(ORR, 5'd7, 5'd2, 5'd13), 64'h12C,
          mk(64'h12C, 64'd7, 64'hABCD, 64'd0, 5'd2, 5'd7, 5'd13, C_R), 1, 0);
    issue({11'h7FF, 21'h0}, 64'h130,
          mk(64'h130, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, C_ILL), 1, 0);

    // flush with a fresh instruction presented
    step();
    in_inst = 32'h8B020023; in_pc = 64'h134; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {63'b0, out_valid}, 64'd0);

    // flush while stalled behind a load
    issue(d_t(LDR, 9'd8, 5'd1, 5'd4), 64'h138, mk('0, '0, '0, '0, '0, '0, '0, '0), 0, 0);
    in_inst = r_t(ADD, 5'd2, 5'd4, 5'd5); in_pc = 64'h13C; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_stall_ready", {63'b0, in_ready}, 64'd0);
    step();
    flush = 1'b0;
    chk("flush_stall_valid", {63'b0, out_valid}, 64'd0);
    issue(r_t(ADD, 5'd2, 5'd4, 5'd5), 64'h13C,
          mk(64'h13C, 64'h40, 64'd7, 64'd0, 5'd4, 5'd2, 5'd5, C_R), 1, 0);

    // back-pressure: ID/EX holds while out_ready is low
    issue(32'h8B020023, 64'h140, mk(64'h140, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3, C_R), 1, 0);
    out_ready = 1'b0;
    in_inst = r_t(SUB, 5'd1, 5'd7, 5'd11); in_pc = 64'h144; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
      chk("hold_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_rd", 64'(out_rd), 64'd3);
      chk("hold_pc", out_pc, 64'h140);
      step();
    end
    out_ready = 1'b1;
    issue(r_t(SUB, 5'd1, 5'd7, 5'd11), 64'h144,
          mk(64'h144, 64'hABCD, 64'd5, 64'd0, 5'd7, 5'd1, 5'd11, C_R), 1, 0);

    // reset in the middle of a load-use stall
    issue(d_t(LDR, 9'd8, 5'd1, 5'd4), 64'h148, mk('0, '0, '0, '0, '0, '0, '0, '0), 0, 0);
    in_inst = r_t(ADD, 5'd2, 5'd4, 5'd5); in_pc = 64'h14C; in_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rst_stall_ready", {63'b0, in_ready}, 64'd0);
    step();
    rst = 1'b0;
    chk("rst_stall_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_stall_memread", {63'b0, out_memread}, 64'd0);
    issue(r_t(ADD, 5'd2, 5'd4, 5'd5), 64'h14C,
          mk(64'h14C, 64'd0, 64'd0, 64'd0, 5'd4, 5'd2, 5'd5, C_R), 1, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
